// File: rtl/bp_cce_inst_fetch_stage.sv
// CCE microcode fetch stage: instruction RAM, PC and fetch sequencing.
// Microcode is loaded through the cfg port, then fetched from boot_pc_i once start_i is seen.
//
// state  | meaning
// e_load | accept microcode writes; no fetch
// e_init | one cycle: read boot_pc_i into the RAM output
// e_run  | fetch; sequential, stall or redirect each cycle
module bp_cce_inst_fetch_stage #(
  parameter int cce_pc_width_p    = 8,
  parameter int cce_instr_width_p = 48
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         cfg_w_v_i,
  input  logic [cce_pc_width_p-1:0]    cfg_addr_i,
  input  logic [cce_instr_width_p-1:0] cfg_data_i,
  input  logic                         start_i,
  input  logic [cce_pc_width_p-1:0]    boot_pc_i,
  input  logic                         stall_i,
  input  logic                         branch_v_i,
  input  logic [cce_pc_width_p-1:0]    branch_target_i,
  output logic [cce_pc_width_p-1:0]    fetch_pc_o,
  output logic                         instruction_v_o,
  output logic [cce_instr_width_p-1:0] instruction_o,
  output logic                         running_o,
  output logic                         cfg_err_o
);

  localparam int depth_lp = 2 ** cce_pc_width_p;
  localparam logic [cce_pc_width_p-1:0] pc_one_lp = {{(cce_pc_width_p-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    e_load = 2'd0,
    e_init = 2'd1,
    e_run  = 2'd2
  } state_e;

  state_e state_r, state_n;

  logic [cce_pc_width_p-1:0]    pc_r, pc_n;
  logic                         cfg_err_r, cfg_err_n;
  logic                         mem_v, mem_w;
  logic [cce_pc_width_p-1:0]    mem_addr;
  logic [cce_instr_width_p-1:0] mem [depth_lp];
  logic [cce_instr_width_p-1:0] rd_data_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= e_load;
      pc_r      <= '0;
      cfg_err_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      pc_r      <= pc_n;
      cfg_err_r <= cfg_err_n;
    end
  end

  always_comb begin
    state_n   = state_r;
    pc_n      = pc_r;
    cfg_err_n = cfg_err_r;
    mem_v     = 1'b0;
    mem_w     = 1'b0;
    mem_addr  = pc_r;

    // Config writes are only legal while loading; elsewhere they just flag an error.
    if (cfg_w_v_i && (state_r != e_load)) cfg_err_n = 1'b1;

    unique case (state_r)
      e_load: begin
        if (cfg_w_v_i) begin
          mem_v    = 1'b1;
          mem_w    = 1'b1;
          mem_addr = cfg_addr_i;
        end
        if (start_i) state_n = e_init;
      end
      e_init: begin
        mem_v    = 1'b1;
        mem_addr = boot_pc_i;
        pc_n     = boot_pc_i;
        state_n  = e_run;
      end
      e_run: begin
        // A branch means the current instruction was consumed, so it overrides stall.
        if (branch_v_i) begin
          mem_v    = 1'b1;
          mem_addr = branch_target_i;
          pc_n     = branch_target_i;
        end else if (!stall_i) begin
          mem_v    = 1'b1;
          mem_addr = pc_r + pc_one_lp;
          pc_n     = pc_r + pc_one_lp;
        end
      end
      default: state_n = e_load;
    endcase
  end

  // 1rw synchronous RAM; read data holds until the next read. Not reset.
  always_ff @(posedge clk_i) begin
    if (mem_v) begin
      if (mem_w) mem[mem_addr] <= cfg_data_i;
      else       rd_data_r     <= mem[mem_addr];
    end
  end

  assign fetch_pc_o      = pc_r;
  assign instruction_o   = rd_data_r;
  assign instruction_v_o = (state_r == e_run);
  assign running_o       = (state_r == e_run);
  assign cfg_err_o       = cfg_err_r;

endmodule
